// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, owns pc and the retired counter.
// Optional macro UC_ILLEGAL_TRAP_EN: illegal opcodes trap instead of retiring as NOPs.
module uc_multiciclo #(
  parameter int OP_W    = 4,
  parameter int PC_W    = 64,
  parameter int PC_STEP = 4,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  output logic             we_ir,
  output logic             we_reg,
  output logic             we_mem,
  output logic             sel_b,
  output logic             sel_wb,
  output logic             alu_sub,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired,
  output logic             busy,
  output logic             halted
`ifdef UC_ILLEGAL_TRAP_EN
  ,
  output logic             trap
`endif
);

  localparam int LC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(2);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SUBI  = OP_W'(6);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_TRAP
  } state_t;

  state_t            state, state_d;
  logic [OP_W-1:0]   op_q;
  logic [PC_W-1:0]   pc_q;
  logic [CNT_W-1:0]  retired_q;
  logic [LC_W-1:0]   lat_cnt;

  logic retire, lat_load;
  logic we_ir_c, we_reg_c, we_mem_c;
  logic sel_b_c, sel_wb_c, alu_sub_c;

  // Next-state and write-enable logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state;
    retire   = 1'b0;
    lat_load = 1'b0;
    we_ir_c  = 1'b0;
    we_reg_c = 1'b0;
    we_mem_c = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        we_ir_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALTED;
        end else if (opcode <= OP_SUBI) begin
          state_d = S_EXEC;
        end else begin
`ifdef UC_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (op_q == OP_LOAD || op_q == OP_STORE) begin
          lat_load = 1'b1;
          state_d  = S_MEM;
        end else begin
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        if (lat_cnt == '0) begin
          if (op_q == OP_STORE) begin
            we_mem_c = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        we_reg_c = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath selects follow the latched opcode only while the instruction is in flight.
  always_comb begin
    sel_b_c   = 1'b0;
    sel_wb_c  = 1'b0;
    alu_sub_c = 1'b0;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      unique case (op_q)
        OP_ADD:  begin sel_b_c = 1'b1; sel_wb_c = 1'b1; end
        OP_SUB:  begin sel_b_c = 1'b1; sel_wb_c = 1'b1; alu_sub_c = 1'b1; end
        OP_ADDI: sel_wb_c = 1'b1;
        OP_SUBI: begin sel_wb_c = 1'b1; alu_sub_c = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      pc_q      <= '0;
      retired_q <= '0;
      lat_cnt   <= '0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) op_q <= opcode;
      if (retire) begin
        pc_q      <= pc_q + PC_W'(PC_STEP);
        retired_q <= retired_q + CNT_W'(1);
      end
      if (lat_load)
        lat_cnt <= LC_W'(MEM_LAT - 1);
      else if (state == S_MEM && lat_cnt != '0)
        lat_cnt <= lat_cnt - LC_W'(1);
    end
  end

  // NOTE: outputs are forced low by rst combinationally, so no write escapes during the reset cycle.
  assign we_ir   = we_ir_c   & ~rst;
  assign we_reg  = we_reg_c  & ~rst;
  assign we_mem  = we_mem_c  & ~rst;
  assign sel_b   = sel_b_c   & ~rst;
  assign sel_wb  = sel_wb_c  & ~rst;
  assign alu_sub = alu_sub_c & ~rst;
  assign pc      = rst ? '0 : pc_q;
  assign retired = rst ? '0 : retired_q;
  assign busy    = ~rst & (state != S_IDLE) & (state != S_HALTED) & (state != S_TRAP);
  assign halted  = ~rst & (state == S_HALTED);
`ifdef UC_ILLEGAL_TRAP_EN
  assign trap    = ~rst & (state == S_TRAP);
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: two instances (MEM_LAT=1 and MEM_LAT=3) checked per cycle
// against a latency-table model of each instruction.
module tb_uc_multiciclo;

  localparam int OP_W    = 4;
  localparam int PC_W    = 64;
  localparam int PC_STEP = 4;
  localparam int CNT_W   = 32;

  typedef struct packed {
    logic we_ir, we_reg, we_mem, sel_b, sel_wb, alu_sub, busy, halted, trap;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start_v   [2];
  logic [OP_W-1:0]  op_v      [2];
  logic             we_ir_v   [2];
  logic             we_reg_v  [2];
  logic             we_mem_v  [2];
  logic             sel_b_v   [2];
  logic             sel_wb_v  [2];
  logic             alu_sub_v [2];
  logic             busy_v    [2];
  logic             halted_v  [2];
  logic [PC_W-1:0]  pc_v      [2];
  logic [CNT_W-1:0] ret_v     [2];
`ifdef UC_ILLEGAL_TRAP_EN
  logic             trap_v    [2];
`endif

  uc_multiciclo #(.OP_W(OP_W), .PC_W(PC_W), .PC_STEP(PC_STEP), .MEM_LAT(1), .CNT_W(CNT_W)) u_lat1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .opcode(op_v[0]),
    .we_ir(we_ir_v[0]), .we_reg(we_reg_v[0]), .we_mem(we_mem_v[0]),
    .sel_b(sel_b_v[0]), .sel_wb(sel_wb_v[0]), .alu_sub(alu_sub_v[0]),
    .pc(pc_v[0]), .retired(ret_v[0]), .busy(busy_v[0]), .halted(halted_v[0])
`ifdef UC_ILLEGAL_TRAP_EN
    , .trap(trap_v[0])
`endif
  );

  uc_multiciclo #(.OP_W(OP_W), .PC_W(PC_W), .PC_STEP(PC_STEP), .MEM_LAT(3), .CNT_W(CNT_W)) u_lat3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .opcode(op_v[1]),
    .we_ir(we_ir_v[1]), .we_reg(we_reg_v[1]), .we_mem(we_mem_v[1]),
    .sel_b(sel_b_v[1]), .sel_wb(sel_wb_v[1]), .alu_sub(alu_sub_v[1]),
    .pc(pc_v[1]), .retired(ret_v[1]), .busy(busy_v[1]), .halted(halted_v[1])
`ifdef UC_ILLEGAL_TRAP_EN
    , .trap(trap_v[1])
`endif
  );

  int               n_vec = 0;
  int               n_err = 0;
  logic [PC_W-1:0]  m_pc  [2];
  logic [CNT_W-1:0] m_ret [2];
  logic [OP_W-1:0]  prog_q[$];

  function automatic obs_t get_obs(input int s);
    obs_t o;
    o.we_ir   = we_ir_v[s];
    o.we_reg  = we_reg_v[s];
    o.we_mem  = we_mem_v[s];
    o.sel_b   = sel_b_v[s];
    o.sel_wb  = sel_wb_v[s];
    o.alu_sub = alu_sub_v[s];
    o.busy    = busy_v[s];
    o.halted  = halted_v[s];
`ifdef UC_ILLEGAL_TRAP_EN
    o.trap    = trap_v[s];
`else
    o.trap    = 1'b0;
`endif
    return o;
  endfunction

  function automatic int mem_lat(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  // Reference model: instruction length in cycles from FETCH through the last cycle.
  function automatic int instr_len(input int op, input int lat);
    if (op == 0 || op >= 7) return 2;
    if (op == 1) return 4 + lat;
    if (op == 2) return 3 + lat;
    return 4;
  endfunction

  // {sel_b, sel_wb, alu_sub} per opcode.
  function automatic logic [2:0] sel_tbl(input int op);
    case (op)
      3: return 3'b110;
      4: return 3'b111;
      5: return 3'b010;
      6: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t exp_cycle(input int op, input int c, input int lat);
    obs_t e;
    int   len;
    e      = '0;
    len    = instr_len(op, lat);
    e.busy = 1'b1;
    if (c == 1) e.we_ir = 1'b1;
    if (c >= 3) {e.sel_b, e.sel_wb, e.alu_sub} = sel_tbl(op);
    if (c == len && (op == 1 || (op >= 3 && op <= 6))) e.we_reg = 1'b1;
    if (c == len && op == 2) e.we_mem = 1'b1;
    return e;
  endfunction

  task automatic apply_reset(input string tag);
    obs_t o;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin start_v[s] = 1'b0; op_v[s] = '0; end
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = get_obs(s);
      n_vec++;
      if (o !== obs_t'(0) || pc_v[s] !== '0 || ret_v[s] !== '0) begin
        n_err++;
        $display("FAIL %s_in_reset inst%0d: got ctl=%b pc=%0d ret=%0d, want ctl=0 pc=0 ret=0",
                 tag, s, o, pc_v[s], ret_v[s]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = get_obs(s);
      n_vec++;
      if (o !== obs_t'(0) || pc_v[s] !== '0 || ret_v[s] !== '0) begin
        n_err++;
        $display("FAIL %s_idle inst%0d: got ctl=%b pc=%0d ret=%0d, want ctl=0 pc=0 ret=0",
                 tag, s, o, pc_v[s], ret_v[s]);
      end
      m_pc[s]  = '0;
      m_ret[s] = '0;
    end
  endtask

  // Runs prog_q on instance s from IDLE; stops at HALT or a trap.
  task automatic run_program(input int s, input string tag);
    obs_t o, e;
    int   op, len;
    @(posedge clk); #1;
    start_v[s] = 1'b1;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    foreach (prog_q[i]) begin
      op       = int'(prog_q[i]);
      len      = instr_len(op, mem_lat(s));
      op_v[s]  = prog_q[i];
      for (int c = 1; c <= len; c++) begin
        @(negedge clk);
        o = get_obs(s);
        e = exp_cycle(op, c, mem_lat(s));
        n_vec++;
        if (o !== e || pc_v[s] !== m_pc[s] || ret_v[s] !== m_ret[s]) begin
          n_err++;
          $display("FAIL %s inst%0d i%0d op%0d cyc%0d: got ctl=%b pc=%0d ret=%0d, want ctl=%b pc=%0d ret=%0d",
                   tag, s, i, op, c, o, pc_v[s], ret_v[s], e, m_pc[s], m_ret[s]);
        end
        @(posedge clk); #1;
      end
      e = '0;
      if (op == 0) e.halted = 1'b1;
`ifdef UC_ILLEGAL_TRAP_EN
      else if (op >= 7) e.trap = 1'b1;
`endif
      if (e != obs_t'(0)) begin
        // Terminal state: must hold through repeated start pulses.
        for (int k = 0; k < 3; k++) begin
          start_v[s] = (k != 0);
          @(negedge clk);
          o = get_obs(s);
          n_vec++;
          if (o !== e || pc_v[s] !== m_pc[s] || ret_v[s] !== m_ret[s]) begin
            n_err++;
            $display("FAIL %s_terminal inst%0d k%0d: got ctl=%b pc=%0d ret=%0d, want ctl=%b pc=%0d ret=%0d",
                     tag, s, k, o, pc_v[s], ret_v[s], e, m_pc[s], m_ret[s]);
          end
          @(posedge clk); #1;
        end
        start_v[s] = 1'b0;
        return;
      end
      m_pc[s]  = m_pc[s] + PC_W'(PC_STEP);
      m_ret[s] = m_ret[s] + CNT_W'(1);
    end
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_add();
    apply_reset("add_rst");
    prog_q = {};
    prog_q.push_back(OP_W'(3));
    run_program(0, "add");
    n_vec++;
    if (m_pc[0] !== PC_W'(4) || ret_v[0] !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL add_retire: got pc=%0d ret=%0d, want pc=4 ret=1", pc_v[0], ret_v[0]);
    end
  endtask

  task automatic test_load_lat3();
    apply_reset("load_rst");
    prog_q = {};
    prog_q.push_back(OP_W'(1));
    run_program(1, "load_lat3");
    @(negedge clk);
    n_vec++;
    if (pc_v[1] !== PC_W'(4) || ret_v[1] !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL load_retire: got pc=%0d ret=%0d, want pc=4 ret=1", pc_v[1], ret_v[1]);
    end
  endtask

  task automatic test_store();
    apply_reset("store_rst");
    prog_q = {};
    prog_q.push_back(OP_W'(2));
    run_program(0, "store");
    @(negedge clk);
    n_vec++;
    if (pc_v[0] !== PC_W'(4) || ret_v[0] !== CNT_W'(1)) begin
      n_err++;
      $display("FAIL store_retire: got pc=%0d ret=%0d, want pc=4 ret=1", pc_v[0], ret_v[0]);
    end
  endtask

  task automatic test_halt_seq();
    apply_reset("halt_rst");
    prog_q = {};
    prog_q.push_back(OP_W'(5));
    prog_q.push_back(OP_W'(6));
    prog_q.push_back(OP_W'(0));
    run_program(0, "halt_seq");
    @(negedge clk);
    n_vec++;
    if (halted_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || pc_v[0] !== PC_W'(8) || ret_v[0] !== CNT_W'(2)) begin
      n_err++;
      $display("FAIL halt_final: got halted=%b busy=%b pc=%0d ret=%0d, want halted=1 busy=0 pc=8 ret=2",
               halted_v[0], busy_v[0], pc_v[0], ret_v[0]);
    end
  endtask

  task automatic test_illegal();
    apply_reset("illegal_rst");
    prog_q = {};
    prog_q.push_back(OP_W'(9));
    prog_q.push_back(OP_W'(3));
    prog_q.push_back(OP_W'(0));
    run_program(0, "illegal");
    @(negedge clk);
    n_vec++;
`ifdef UC_ILLEGAL_TRAP_EN
    if (trap_v[0] !== 1'b1 || pc_v[0] !== '0 || ret_v[0] !== '0) begin
      n_err++;
      $display("FAIL illegal_trap: got trap=%b pc=%0d ret=%0d, want trap=1 pc=0 ret=0",
               trap_v[0], pc_v[0], ret_v[0]);
    end
`else
    if (halted_v[0] !== 1'b1 || pc_v[0] !== PC_W'(8) || ret_v[0] !== CNT_W'(2)) begin
      n_err++;
      $display("FAIL illegal_nop: got halted=%b pc=%0d ret=%0d, want halted=1 pc=8 ret=2",
               halted_v[0], pc_v[0], ret_v[0]);
    end
`endif
  endtask

  task automatic test_reset_mid_wb();
    obs_t o;
    apply_reset("midwb_rst");
    prog_q = {};
    prog_q.push_back(OP_W'(3));
    run_program(0, "midwb_first");
    // Second ADD is now in FETCH; advance to its WB cycle.
    op_v[0] = OP_W'(3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    o = get_obs(0);
    n_vec++;
    if (o !== obs_t'(0) || pc_v[0] !== '0 || ret_v[0] !== '0) begin
      n_err++;
      $display("FAIL midwb_reset_cycle: got ctl=%b pc=%0d ret=%0d, want ctl=0 pc=0 ret=0",
               o, pc_v[0], ret_v[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    o = get_obs(0);
    n_vec++;
    if (o !== obs_t'(0) || pc_v[0] !== '0 || ret_v[0] !== '0) begin
      n_err++;
      $display("FAIL midwb_idle: got ctl=%b pc=%0d ret=%0d, want ctl=0 pc=0 ret=0",
               o, pc_v[0], ret_v[0]);
    end
  endtask

  task automatic test_random();
    int r, n;
    for (int s = 0; s < 2; s++) begin
      for (int round = 0; round < 3; round++) begin
        apply_reset("rand_rst");
        prog_q = {};
        n = $urandom_range(15, 6);
        for (int i = 0; i < n; i++) begin
          r = $urandom_range(12, 0);
          if (r < 6)       prog_q.push_back(OP_W'(r + 1));
          else if (r == 6) prog_q.push_back(OP_W'($urandom_range(15, 7)));
          else             prog_q.push_back(OP_W'($urandom_range(6, 1)));
        end
        prog_q.push_back(OP_W'(0));
        run_program(s, "random");
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin start_v[s] = 1'b0; op_v[s] = '0; end
    test_reset();
    test_add();
    test_load_lat3();
    test_store();
    test_halt_seq();
    test_illegal();
    test_reset_mid_wb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
